// File: rtl/player_executor_pkg.sv
// Shared game definitions: opcodes, move directions, player state enum and instruction layout.
// Also carries the clamped single-step position helper used by the mover.
package player_executor_pkg;

    localparam logic [3:0] OP_HPY = 4'd1;
    localparam logic [3:0] OP_DPY = 4'd2;
    localparam logic [3:0] OP_IDG = 4'd3;
    localparam logic [3:0] OP_SDG = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_SHP = 4'd6;

    localparam logic [7:0] DIR_UP    = 8'd0;
    localparam logic [7:0] DIR_LEFT  = 8'd1;
    localparam logic [7:0] DIR_DOWN  = 8'd2;
    localparam logic [7:0] DIR_RIGHT = 8'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALIVE  = 2'd1,
        ST_INVULN = 2'd2,
        ST_DEAD   = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] operand;
        logic [3:0] rsvd;
    } instr_t;

    // Evaluated in int so a step near either bound saturates instead of wrapping.
    function automatic logic [7:0] step_clamp(input logic [7:0] pos, input logic dec,
                                              input int step, input int lo, input int hi);
        int p;
        p = dec ? (int'(pos) - step) : (int'(pos) + step);
        if (p < lo) p = lo;
        if (p > hi) p = hi;
        return p[7:0];
    endfunction

endpackage

// File: rtl/player_mover.sv
// Move-tick divider and clamped X/Y position registers.
// Latency: position updates on the cycle the divider reaches MOVE_DIV-1; no backpressure.
module player_mover
    import player_executor_pkg::*;
#(
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 200,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 150,
    parameter int STEP     = 2,
    parameter int MOVE_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_init,
    input  logic       i_en,
    input  logic [7:0] i_dir,
    output logic [7:0] o_x,
    output logic [7:0] o_y
);

    logic [7:0] r_cnt;
    logic [7:0] r_x;
    logic [7:0] r_y;
    logic       w_tick;

    assign w_tick = i_en && (r_cnt == 8'(MOVE_DIV - 1));
    assign o_x    = r_x;
    assign o_y    = r_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
            r_x   <= 8'd0;
            r_y   <= 8'd0;
        end else if (i_init) begin
            r_cnt <= 8'd0;
            r_x   <= 8'((X_MIN + X_MAX) / 2);
            r_y   <= 8'((Y_MIN + Y_MAX) / 2);
        end else begin
            // Any gap in the move condition restarts the divider from zero.
            r_cnt <= (!i_en || w_tick) ? 8'd0 : r_cnt + 8'd1;
            if (w_tick) begin
                case (i_dir)
                    DIR_UP:    r_y <= step_clamp(r_y, 1'b1, STEP, Y_MIN, Y_MAX);
                    DIR_LEFT:  r_x <= step_clamp(r_x, 1'b1, STEP, X_MIN, X_MAX);
                    DIR_DOWN:  r_y <= step_clamp(r_y, 1'b0, STEP, Y_MIN, Y_MAX);
                    DIR_RIGHT: r_x <= step_clamp(r_x, 1'b0, STEP, X_MIN, X_MAX);
                    default:   ;
                endcase
            end
        end
    end

endmodule

// File: rtl/player_executor.sv
// Executes player instruction words: heal/damage/set-HP once per distinct word, init and move while held.
// Latency: one cycle from instruction to registered outputs; no backpressure, input sampled every cycle.
module player_executor
    import player_executor_pkg::*;
#(
    parameter int MAX_HP   = 100,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 200,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 150,
    parameter int STEP     = 2,
    parameter int MOVE_DIV = 4,
    parameter int IFRAME   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] playerInstruction,
    input  logic        isMove,
    output logic [7:0]  playerX,
    output logic [7:0]  playerY,
    output logic [7:0]  playerHP,
    output logic        isDeath,
    output logic        dmgApplied,
    output logic        invuln
);

    localparam logic [7:0] HP_MAX8  = 8'(MAX_HP);
    localparam logic [7:0] IFR_LOAD = 8'(IFRAME - 1);

    instr_t     w_instr;
    instr_t     r_last;
    logic       r_armed;
    state_e     r_state;
    state_e     w_state_nxt;
    logic [7:0] r_hp;
    logic [7:0] w_hp_nxt;
    logic [7:0] r_ifr;
    logic [7:0] w_ifr_nxt;
    logic       r_dmg;
    logic       w_new;
    logic       w_live;
    logic       w_idg;
    logic       w_hpy;
    logic       w_dpy;
    logic       w_shp;
    logic       w_mov;
    logic [8:0] w_heal_sum;
    logic [7:0] w_dmg_hp;

    assign w_instr = playerInstruction;
    // r_armed blocks execution in the first clock after reset release.
    assign w_new   = r_armed && (w_instr != r_last);
    assign w_live  = (r_state == ST_ALIVE) || (r_state == ST_INVULN);
    assign w_idg   = r_armed && (w_instr.op == OP_IDG);
    assign w_hpy   = w_new && (w_instr.op == OP_HPY) && w_live;
    assign w_dpy   = w_new && (w_instr.op == OP_DPY) && (r_state == ST_ALIVE);
    assign w_shp   = w_new && (w_instr.op == OP_SHP) && w_live;
    assign w_mov   = r_armed && (w_instr.op == OP_MOV) && isMove && w_live;

    assign w_heal_sum = {1'b0, r_hp} + {1'b0, w_instr.operand};
    assign w_dmg_hp   = (r_hp > w_instr.operand) ? (r_hp - w_instr.operand) : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_idg)                                   w_state_nxt = ST_ALIVE;
        else if (w_dpy)                              w_state_nxt = (w_dmg_hp == 8'd0) ? ST_DEAD : ST_INVULN;
        else if (w_shp && w_instr.operand == 8'd0)   w_state_nxt = ST_DEAD;
        else if (r_state == ST_INVULN && r_ifr == 8'd0) w_state_nxt = ST_ALIVE;
    end

    always_comb begin
        w_hp_nxt = r_hp;
        if (w_idg)      w_hp_nxt = HP_MAX8;
        else if (w_dpy) w_hp_nxt = w_dmg_hp;
        else if (w_shp) w_hp_nxt = (w_instr.operand > HP_MAX8) ? HP_MAX8 : w_instr.operand;
        else if (w_hpy) w_hp_nxt = (w_heal_sum > {1'b0, HP_MAX8}) ? HP_MAX8 : w_heal_sum[7:0];

        w_ifr_nxt = 8'd0;
        if (w_dpy && w_state_nxt == ST_INVULN)                     w_ifr_nxt = IFR_LOAD;
        else if (r_state == ST_INVULN && w_state_nxt == ST_INVULN) w_ifr_nxt = r_ifr - 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= '0;
            r_armed <= 1'b0;
            r_hp    <= 8'd0;
            r_ifr   <= 8'd0;
            r_dmg   <= 1'b0;
        end else begin
            r_last  <= w_instr;
            r_armed <= 1'b1;
            r_hp    <= w_hp_nxt;
            r_ifr   <= w_ifr_nxt;
            r_dmg   <= w_dpy;
        end
    end

    player_mover #(
        .X_MIN    (X_MIN),
        .X_MAX    (X_MAX),
        .Y_MIN    (Y_MIN),
        .Y_MAX    (Y_MAX),
        .STEP     (STEP),
        .MOVE_DIV (MOVE_DIV)
    ) u_mover (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_init (w_idg),
        .i_en   (w_mov),
        .i_dir  (w_instr.operand),
        .o_x    (playerX),
        .o_y    (playerY)
    );

    assign playerHP   = r_hp;
    assign isDeath    = (r_state == ST_DEAD);
    assign invuln     = (r_state == ST_INVULN);
    assign dmgApplied = r_dmg;

endmodule

// File: tb/tb_player_executor.sv
// Bench for player_executor: directed scenarios plus random words, checked every cycle against a rule-level model.
module tb_player_executor;

    localparam int S_IDLE = 0, S_ALIVE = 1, S_INV = 2, S_DEAD = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        is_move = 1'b0;
    logic [7:0]  playerX, playerY, playerHP;
    logic        isDeath, dmgApplied, invuln;

    int n_pass = 0, n_total = 0, n_fail = 0;
    int obs_dmg = 0, obs_inv = 0;

    // Reference model state
    int          m_st, m_hp, m_x, m_y, m_run, m_inv, m_dmg;
    bit          m_armed;
    logic [15:0] m_last;

    always #5 clk = ~clk;

    player_executor u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .playerInstruction (instr),
        .isMove            (is_move),
        .playerX           (playerX),
        .playerY           (playerY),
        .playerHP          (playerHP),
        .isDeath           (isDeath),
        .dmgApplied        (dmgApplied),
        .invuln            (invuln)
    );

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic void model_reset();
        m_st = S_IDLE; m_hp = 0; m_x = 0; m_y = 0; m_run = 0; m_inv = 0; m_dmg = 0;
        m_armed = 1'b0; m_last = 16'h0000;
    endfunction

    function automatic void model_step(input logic [15:0] w, input logic mv);
        int op, arg;
        bit fresh, live, entered;
        op      = int'(w[15:12]);
        arg     = int'(w[11:4]);
        fresh   = m_armed && (w != m_last);
        live    = (m_st == S_ALIVE) || (m_st == S_INV);
        m_dmg   = 0;
        entered = 1'b0;
        if (!m_armed) begin
            m_run = 0;
        end else if (op == 3) begin
            m_hp = 100; m_x = 100; m_y = 75; m_st = S_ALIVE; m_run = 0; m_inv = 0;
        end else begin
            if (fresh && op == 2 && m_st == S_ALIVE) begin
                m_hp  = (m_hp > arg) ? m_hp - arg : 0;
                m_dmg = 1;
                if (m_hp == 0) m_st = S_DEAD;
                else begin m_st = S_INV; m_inv = 16; entered = 1'b1; end
            end else if (fresh && op == 6 && live) begin
                m_hp = (arg > 100) ? 100 : arg;
                if (arg == 0) m_st = S_DEAD;
            end else if (fresh && op == 1 && live) begin
                m_hp = (m_hp + arg > 100) ? 100 : m_hp + arg;
            end
            if (m_st == S_INV && !entered) begin
                m_inv--;
                if (m_inv == 0) m_st = S_ALIVE;
            end
            if (op == 5 && mv && live) begin
                m_run++;
                if (m_run % 4 == 0) begin
                    case (arg)
                        0: m_y = clampi(m_y - 2, 0, 150);
                        1: m_x = clampi(m_x - 2, 0, 200);
                        2: m_y = clampi(m_y + 2, 0, 150);
                        3: m_x = clampi(m_x + 2, 0, 200);
                        default: ;
                    endcase
                end
            end else begin
                m_run = 0;
            end
        end
        m_last  = w;
        m_armed = 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("hp",     playerHP,   m_hp);
        chk("x",      playerX,    m_x);
        chk("y",      playerY,    m_y);
        chk("death",  isDeath,    (m_st == S_DEAD) ? 1 : 0);
        chk("invuln", invuln,     (m_st == S_INV) ? 1 : 0);
        chk("dmg",    dmgApplied, m_dmg);
        if (dmgApplied === 1'b1) obs_dmg++;
        if (invuln === 1'b1)     obs_inv++;
    endtask

    task automatic cyc(input logic [15:0] w, input logic mv);
        instr   = w;
        is_move = mv;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step(w, mv);
        #1;
        check_all();
    endtask

    task automatic cycn(input logic [15:0] w, input logic mv, input int n);
        for (int k = 0; k < n; k++) cyc(w, mv);
    endtask

    task automatic mid_reset();
        #3 rst_n = 1'b0;
        #1 model_reset();
        check_all();
    endtask

    initial begin
        logic [15:0] cur;
        int          ops[12] = '{1, 2, 2, 5, 5, 5, 6, 1, 4, 0, 7, 12};
        int          op, arg;
        logic [7:0]  y_hold;

        model_reset();
        #1 check_all();
        cycn(16'h0000, 1'b0, 2);
        rst_n = 1'b1;

        // Release cycle ignores IDG; the following one applies it
        cyc(16'h3000, 1'b0);
        chk("release_hp", playerHP, 0);
        cyc(16'h3000, 1'b0);
        chk("idg_hp", playerHP, 100);
        chk("idg_x",  playerX, 100);
        chk("idg_y",  playerY, 75);
        cyc(16'h0000, 1'b0);

        // Damage held, second damage during INVULN ignored
        obs_dmg = 0; obs_inv = 0;
        cycn(16'h21E0, 1'b0, 10);
        cyc(16'h0000, 1'b0);
        cycn(16'h21E0, 1'b0, 2);
        cycn(16'h0000, 1'b0, 12);
        chk("dpy_hp", playerHP, 70);
        chk("dpy_pulses", obs_dmg, 1);
        chk("inv_cycles", obs_inv, 16);

        // Heal saturates, SHP 0 kills, movement frozen while dead, IDG revives
        cyc(16'h1320, 1'b0);
        chk("hpy_sat", playerHP, 100);
        cyc(16'h6000, 1'b0);
        chk("shp0_dead", isDeath, 1);
        y_hold = playerY;
        cycn(16'h5000, 1'b1, 8);
        chk("dead_move_y", playerY, y_hold);
        cyc(16'h3000, 1'b0);
        chk("revive", isDeath, 0);

        // Clamp at bounds, including odd distance to the edge
        cycn(16'h5000, 1'b1, 160);
        chk("y_top", playerY, 0);
        cyc(16'h3000, 1'b0);
        cycn(16'h5020, 1'b1, 160);
        chk("y_bottom", playerY, 150);
        cycn(16'h5030, 1'b1, 210);
        chk("x_right", playerX, 200);
        cycn(16'h5010, 1'b1, 410);
        chk("x_left", playerX, 0);

        // isMove toggling every 3 cycles never completes a tick
        cyc(16'h3000, 1'b0);
        for (int k = 0; k < 8; k++) cycn(16'h5030, k[0] ? 1'b0 : 1'b1, 3);
        chk("toggle_x", playerX, 100);

        // Random words with holds and occasional resets
        cur = 16'h3000;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                mid_reset();
                cyc(cur, 1'b0);
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 24) == 0) op = 3;
                else op = ops[$urandom_range(0, 11)];
                case (op)
                    5: arg = $urandom_range(0, 5);
                    6: arg = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 130);
                    2: arg = $urandom_range(0, 60);
                    default: arg = $urandom_range(0, 255);
                endcase
                cur = {op[3:0], arg[7:0], 4'($urandom_range(0, 15))};
            end
            cyc(cur, ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0);
        end

        // Lethal damage then asynchronous reset mid-move
        cyc(16'h3000, 1'b0);
        cyc(16'h6140, 1'b0);
        chk("shp20", playerHP, 20);
        obs_dmg = 0;
        cyc(16'h2190, 1'b0);
        chk("lethal_hp", playerHP, 0);
        chk("lethal_dead", isDeath, 1);
        chk("lethal_pulse", obs_dmg, 1);
        cyc(16'h3000, 1'b0);
        cycn(16'h5010, 1'b1, 3);
        mid_reset();
        chk("rst_hp", playerHP, 0);
        chk("rst_x", playerX, 0);
        cyc(16'h5010, 1'b1);
        rst_n = 1'b1;
        cyc(16'h3000, 1'b0);
        cyc(16'h3000, 1'b0);
        cycn(16'h5010, 1'b1, 6);
        chk("post_rst_x", playerX, 98);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/player_executor.md
PLAYER_EXECUTOR -- requirements
Module: player_executor

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- MAX_HP, 100, HP ceiling and IDG start value.
- X_MIN/X_MAX, 0/200, arena X bounds.
- Y_MIN/Y_MAX, 0/150, arena Y bounds.
- STEP, 2, pixels per move tick.
- MOVE_DIV, 4, cycles between move ticks.
- IFRAME, 16, invulnerability cycles after damage.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, system clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- playerInstruction, in, 16, instruction word: [15:12] op, [11:4] operand, [3:0] ignored.
- isMove, in, 1, MOV enable, sampled every cycle.
- playerX, out, 8, player X position.
- playerY, out, 8, player Y position.
- playerHP, out, 8, current HP.
- isDeath, out, 1, high while in DEAD state.
- dmgApplied, out, 1, one-cycle pulse when a DPY changes HP.
- invuln, out, 1, high during INVULN state.

Function
REQ-003 Opcodes SHALL be: HPY=1 (heal), DPY=2 (damage), IDG=3 (init dodge), SDG=4 (no-op), MOV=5 (move), SHP=6 (set HP). 0 and 7-15 are no-ops.
REQ-004 State machine SHALL have states IDLE, ALIVE, INVULN, DEAD; reset state is IDLE.
REQ-005 IDG in any state SHALL, next cycle: set HP=MAX_HP, X=(X_MIN+X_MAX)/2, Y=(Y_MIN+Y_MAX)/2, move counter=0, state=ALIVE.
REQ-006 HPY, DPY and SHP SHALL each execute once per distinct instruction word. A word executes only when it differs from the last registered word, which SHALL update every cycle. Repeats of a held word are ignored.
REQ-007 HPY SHALL set HP = min(HP+operand, MAX_HP), computed 9-bit with no wrap. It is honoured in ALIVE and INVULN only.
REQ-008 DPY in ALIVE SHALL set HP = max(HP-operand, 0), pulse dmgApplied for 1 cycle, and enter INVULN with IFRAME counter loaded. DPY in INVULN, IDLE or DEAD SHALL be ignored with no pulse.
REQ-009 DPY with operand 0 in ALIVE SHALL still pulse dmgApplied and enter INVULN.
REQ-010 If a DPY result is HP=0, state SHALL go to DEAD instead of INVULN, in the same cycle; dmgApplied still pulses.
REQ-011 SHP SHALL set HP = min(operand, MAX_HP) in ALIVE/INVULN. SHP with operand 0 SHALL go to DEAD.
REQ-012 INVULN SHALL return to ALIVE after exactly IFRAME cycles; invuln is high for exactly those IFRAME cycles.
REQ-013 MOV SHALL require isMove=1 and state ALIVE or INVULN.
- The free-running move counter counts while MOV and isMove are active; a tick occurs when it reaches MOVE_DIV-1, then it wraps to 0.
- The counter SHALL be cleared whenever MOV or isMove is inactive.
- First step occurs MOVE_DIV cycles after the MOV condition first holds.
REQ-014 Direction operand SHALL be: 0 up (Y-STEP), 1 left (X-STEP), 2 down (Y+STEP), 3 right (X+STEP); other values do not move.
REQ-015 Positions SHALL clamp to [MIN, MAX] and never wrap, including when the position is within STEP of a bound.
REQ-016 In DEAD, HP, X and Y SHALL hold, and isDeath=1; only IDG leaves DEAD.
REQ-017 All outputs SHALL be registered, with 1-cycle latency from instruction to effect.

Reset
REQ-018 rst_n low SHALL asynchronously force the following, and hold them until release:
- state IDLE; HP=0; X=Y=0; isDeath=0; dmgApplied=0; invuln=0.
- counters 0; last-instruction register 0.
REQ-019 Reset mid-INVULN or mid-move SHALL discard the counters. No instruction executes in the release cycle.

Structure
REQ-020 The opcode and direction constants and the state enum SHALL reside in the shared game package used with the game controller.
REQ-021 One sub-module, player_mover, SHALL hold the move-tick counter and the clamped X/Y update.

Verification
REQ-022 Reset, then IDG -> HP=100, X=100, Y=75, state ALIVE.
REQ-023 DPY operand 30, held 10 cycles -> HP=70, one dmgApplied pulse, invuln high for 16 cycles; a second DPY 30 arriving during INVULN is ignored.
REQ-024 HP=70, HPY 50 -> HP=100 (saturates); then SHP 0 -> isDeath=1; then MOV with isMove=1 -> no change; then IDG -> ALIVE.
REQ-025 X=1, MOV left with isMove=1 for 12 cycles -> X=0 after the first tick, then stays 0; playerY unchanged.
REQ-026 MOV right with isMove toggling every 3 cycles -> no steps (counter cleared each time, MOVE_DIV=4).
REQ-027 HP=20, DPY 25 -> HP=0, dmgApplied pulse, DEAD; assert rst_n low mid-sequence -> all outputs 0 immediately.
